// File: rtl/riscv_alu_arbiter.sv
// riscv_alu_arbiter
//   Shares a single RISC-V ALU between two requesters: port 0 is the core
//   execute stage, port 1 is the aux unit (CSR/debug). A granted request has
//   its op/a/b captured into holding registers. The ALU is evaluated on those
//   held operands and answered on the following cycle.
//
// Handshakes: a transfer on any channel happens on a rising clock edge where
//   the valid bit and the matching ready bit are both high. Requesters may drop
//   req_valid_i without a transfer. The response channel's result and flag hold
//   stable until the owner accepts the response.
//
// Configuration macro: ALU_ARB_FIXED_PRIO_EN
//   undefined (default) : round-robin on contention, starting at PRIO_INIT
//   defined             : requester 0 always wins contention, PRIO_INIT unused
//
// Ports
//   clk_i        in   1   clock
//   rst_n_i      in   1   asynchronous active-low reset
//   req_valid_i  in   2   per-requester request valid
//   req_ready_o  out  2   per-requester request accepted (one-hot or zero)
//   req0_op_i    in   5   requester 0 ALU op
//   req0_a_i     in   32  requester 0 operand A
//   req0_b_i     in   32  requester 0 operand B
//   req1_op_i    in   5   requester 1 ALU op
//   req1_a_i     in   32  requester 1 operand A
//   req1_b_i     in   32  requester 1 operand B
//   rsp_valid_o  out  2   response valid for owner (one-hot or zero)
//   rsp_ready_i  in   2   per-requester response accept
//   rsp_result_o out  32  ALU result of held operation
//   rsp_flag_o   out  1   ALU branch-compare flag of held operation
module riscv_alu_arbiter #(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [4:0]  req0_op_i,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic [4:0]  req1_op_i,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  output logic [1:0]  rsp_valid_o,
  input  logic [1:0]  rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        rsp_flag_o
);

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b01000;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_SRA  = 5'b01101;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_SLL  = 5'b00001;
  localparam logic [4:0] ALU_BLT  = 5'b11100;
  localparam logic [4:0] ALU_BLTU = 5'b11110;
  localparam logic [4:0] ALU_BGE  = 5'b11101;
  localparam logic [4:0] ALU_BGEU = 5'b11111;
  localparam logic [4:0] ALU_BEQ  = 5'b11000;
  localparam logic [4:0] ALU_BNE  = 5'b11001;
  localparam logic [4:0] ALU_SLTS = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state, state_next;
  logic        owner;
  logic [4:0]  hold_op;
  logic [31:0] hold_a, hold_b;
  logic        grant;
  logic        rsp_fire, accept, req_fire;

  // Grant: a lone valid wins; on contention the priority holder wins.
`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = req_valid_i[1] & ~req_valid_i[0];
  end
`else
  logic rr_ptr;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      rr_ptr <= PRIO_INIT;
    else if (req_fire) rr_ptr <= ~grant;
  end

  always_comb begin
    case (req_valid_i)
      2'b10:   grant = 1'b1;
      2'b11:   grant = rr_ptr;
      default: grant = 1'b0;
    endcase
  end
`endif

  // A pending response retiring this cycle reopens the accept window so the
  // next request can be taken back-to-back.
  assign rsp_fire = (state == BUSY) && rsp_ready_i[owner];
  assign accept   = (state == IDLE) || rsp_fire;
  assign req_fire = |(req_valid_i & req_ready_o);

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_fire) state_next = BUSY;
      BUSY:    if (rsp_fire && !req_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; ready is forced low while reset is asserted.
  always_comb begin
    req_ready_o = 2'b00;
    rsp_valid_o = 2'b00;
    if (rst_n_i && accept && (|req_valid_i))
      req_ready_o = grant ? 2'b10 : 2'b01;
    if (state == BUSY)
      rsp_valid_o = owner ? 2'b10 : 2'b01;
  end

  // Holding registers for the granted operation.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner   <= 1'b0;
      hold_op <= 5'd0;
      hold_a  <= 32'd0;
      hold_b  <= 32'd0;
    end else if (req_fire) begin
      owner   <= grant;
      hold_op <= grant ? req1_op_i : req0_op_i;
      hold_a  <= grant ? req1_a_i  : req0_a_i;
      hold_b  <= grant ? req1_b_i  : req0_b_i;
    end
  end

  // Shared ALU on held operands. Unknown codes yield result 0, flag 0.
  always_comb begin
    rsp_result_o = 32'd0;
    rsp_flag_o   = 1'b0;
    case (hold_op)
      ALU_ADD:  rsp_result_o = hold_a + hold_b;
      ALU_SUB:  rsp_result_o = hold_a - hold_b;
      ALU_XOR:  rsp_result_o = hold_a ^ hold_b;
      ALU_OR:   rsp_result_o = hold_a | hold_b;
      ALU_AND:  rsp_result_o = hold_a & hold_b;
      ALU_SRA:  rsp_result_o = $unsigned($signed(hold_a) >>> hold_b[4:0]);
      ALU_SRL:  rsp_result_o = hold_a >> hold_b[4:0];
      ALU_SLL:  rsp_result_o = hold_a << hold_b[4:0];
      ALU_SLTS: rsp_result_o = {31'd0, $signed(hold_a) < $signed(hold_b)};
      ALU_SLTU: rsp_result_o = {31'd0, hold_a < hold_b};
      ALU_BLT:  rsp_flag_o   = $signed(hold_a) < $signed(hold_b);
      ALU_BLTU: rsp_flag_o   = hold_a < hold_b;
      ALU_BGE:  rsp_flag_o   = $signed(hold_a) >= $signed(hold_b);
      ALU_BGEU: rsp_flag_o   = hold_a >= hold_b;
      ALU_BEQ:  rsp_flag_o   = hold_a == hold_b;
      ALU_BNE:  rsp_flag_o   = hold_a != hold_b;
      default: ;
    endcase
  end

endmodule
